// File: rtl/sdram_p2_dma.sv
// sdram_p2_dma: turns one (address, length, direction) command into single-word
// toggle-acknowledged accesses on the SDRAM controller's second port.
module sdram_p2_dma #(
   parameter int FIFO_DEPTH = 4,
   parameter int SETTLE     = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_start,
   input  logic        cmd_we,
   input  logic [21:0] cmd_addr,
   input  logic [15:0] cmd_len,
   output logic        busy,
   output logic        done,
   input  logic [15:0] wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [21:0] p2_addr,
   output logic [15:0] p2_din,
   output logic [1:0]  p2_ds,
   output logic        p2_cs,
   output logic        p2_we,
   input  logic [15:0] p2_dout,
   input  logic        p2_ack
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(SETTLE + 1);
   localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

   typedef enum logic [2:0] {
      S_SETTLE,
      S_IDLE,
      S_WAIT,
      S_REQ,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] settle_q, settle_d;
   logic          ack_seen_q, ack_seen_d;
   logic [21:0]   addr_q, addr_d;
   logic          we_q, we_d;
   logic [15:0]   remain_q, remain_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          p2_cs_q, p2_cs_d;
   logic          p2_we_q, p2_we_d;
   logic [21:0]   p2_addr_q, p2_addr_d;
   logic [15:0]   p2_din_q, p2_din_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [15:0]   mem_q [FIFO_DEPTH];
   logic          push_c, pop_c, ack_edge_c;

   always_comb begin
      state_d    = state_q;
      settle_d   = settle_q;
      ack_seen_d = p2_ack;
      addr_d     = addr_q;
      we_d       = we_q;
      remain_d   = remain_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      p2_cs_d    = p2_cs_q;
      p2_we_d    = p2_we_q;
      p2_addr_d  = p2_addr_q;
      p2_din_d   = p2_din_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      wr_ready   = 1'b0;
      push_c     = 1'b0;
      pop_c      = rd_ready && (count_q != '0);
      ack_edge_c = (p2_ack != ack_seen_q);

      case (state_q)
         S_SETTLE: begin
            // ack_seen keeps tracking p2_ack here, swallowing any toggle from an access cut off by reset
            if (settle_q == SETTLE_LAST) begin
               state_d = S_IDLE;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (cmd_start) begin
               addr_d   = cmd_addr;
               we_d     = cmd_we;
               remain_d = cmd_len;
               busy_d   = 1'b1;
               state_d  = (cmd_len == 16'd0) ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            if ((we_q && wr_valid) || (!we_q && (count_q < DEPTH_C))) begin
               p2_cs_d   = 1'b1;
               p2_addr_d = addr_q;
               p2_we_d   = we_q;
               if (we_q) begin
                  p2_din_d = wr_data;
                  wr_ready = 1'b1;
               end
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            ack_seen_d = ack_seen_q;
            if (ack_edge_c) begin
               p2_cs_d  = 1'b0;
               push_c   = !we_q;
               addr_d   = addr_q + 22'd1;
               remain_d = remain_q - 16'd1;
               state_d  = (remain_q == 16'd1) ? S_DONE : S_WAIT;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_SETTLE;
      endcase

      if (push_c) wptr_d = wptr_q + 1'b1;
      if (pop_c)  rptr_d = rptr_q + 1'b1;
      if (push_c && !pop_c) begin
         count_d = count_q + 1'b1;
      end else if (!push_c && pop_c) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_SETTLE;
         settle_q   <= '0;
         ack_seen_q <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         remain_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         p2_cs_q    <= 1'b0;
         p2_we_q    <= 1'b0;
         p2_addr_q  <= '0;
         p2_din_q   <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         ack_seen_q <= ack_seen_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         remain_q   <= remain_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         p2_cs_q    <= p2_cs_d;
         p2_we_q    <= p2_we_d;
         p2_addr_q  <= p2_addr_d;
         p2_din_q   <= p2_din_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage needs no reset: the flushed pointers make stale words unreachable
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wptr_q] <= p2_dout;
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_data  = mem_q[rptr_q];
   assign rd_valid = (count_q != '0);
   assign p2_addr  = p2_addr_q;
   assign p2_din   = p2_din_q;
   assign p2_ds    = 2'b00;
   assign p2_cs    = p2_cs_q;
   assign p2_we    = p2_we_q;
endmodule

// File: tb/tb_sdram_p2_dma.sv
// Directed bench for sdram_p2_dma: behavioural p2 controller model, a table of
// transfers, and hand sequences for timing, backpressure and reset corners.
module tb_sdram_p2_dma;
   localparam int FIFO_DEPTH = 4;
   localparam int SETTLE     = 16;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        cmd_start = 1'b0;
   logic        cmd_we    = 1'b0;
   logic [21:0] cmd_addr  = '0;
   logic [15:0] cmd_len   = '0;
   logic        busy, done;
   logic [15:0] wr_data   = '0;
   logic        wr_valid  = 1'b0;
   logic        wr_ready;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        rd_ready  = 1'b0;
   logic [21:0] p2_addr;
   logic [15:0] p2_din;
   logic [1:0]  p2_ds;
   logic        p2_cs, p2_we;
   logic [15:0] p2_dout   = '0;
   logic        p2_ack    = 1'b0;

   sdram_p2_dma #(.FIFO_DEPTH(FIFO_DEPTH), .SETTLE(SETTLE)) dut (
      .clk(clk), .reset(reset),
      .cmd_start(cmd_start), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .busy(busy), .done(done),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .p2_addr(p2_addr), .p2_din(p2_din), .p2_ds(p2_ds), .p2_cs(p2_cs), .p2_we(p2_we),
      .p2_dout(p2_dout), .p2_ack(p2_ack)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rd_pat(input logic [21:0] a);
      return a[15:0] ^ 16'h5AC3 ^ {10'd0, a[21:16]};
   endfunction

   // Controller model: samples p2_cs, toggles p2_ack 5 cycles later, then ignores
   // p2_cs for one edge while the DUT drops it.
   int          cyc = 0, acc_n = 0, ack_n = 0, rd_n = 0, wr_n = 0, done_n = 0, ovf_n = 0;
   int          last_ack_cyc = 0, done_cyc = 0;
   int          m_delay = 0, m_cool = 0;
   logic        m_pend = 1'b0;
   logic [21:0] m_addr = '0;
   logic [21:0] acc_addr [256];
   logic        acc_we   [256];
   logic [15:0] acc_din  [256];
   logic [1:0]  acc_ds   [256];
   logic [15:0] rd_got   [256];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_pend) begin
         if (m_delay == 1) begin
            p2_ack       <= ~p2_ack;
            p2_dout      <= rd_pat(m_addr);
            m_pend       <= 1'b0;
            m_cool       <= 1;
            ack_n        <= ack_n + 1;
            last_ack_cyc <= cyc + 1;
         end else begin
            m_delay <= m_delay - 1;
         end
      end else if (m_cool != 0) begin
         m_cool <= m_cool - 1;
      end else if (p2_cs) begin
         m_pend  <= 1'b1;
         m_delay <= 5;
         m_addr  <= p2_addr;
         if (acc_n < 256) begin
            acc_addr[acc_n] <= p2_addr;
            acc_we[acc_n]   <= p2_we;
            acc_din[acc_n]  <= p2_din;
            acc_ds[acc_n]   <= p2_ds;
         end
         acc_n <= acc_n + 1;
      end
   end

   always @(posedge clk) begin
      if (!reset && rd_valid && rd_ready) begin
         if (rd_n < 256) rd_got[rd_n] <= rd_data;
         rd_n <= rd_n + 1;
      end
      if (wr_valid && wr_ready) wr_n <= wr_n + 1;
      if (done) begin
         done_n   <= done_n + 1;
         done_cyc <= cyc;
      end
      if (!reset && dut.push_c && (int'(dut.count_q) >= FIFO_DEPTH)) ovf_n <= ovf_n + 1;
   end

   int n_chk = 0, n_pass = 0;
   int acc_base = 0, rd_base = 0, wr_base = 0, done_base = 0, ack_base = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   typedef struct {
      logic             we;
      logic [21:0]      addr;
      logic [15:0]      len;
      logic [3:0][15:0] wd;
      int               glitch_at;
      logic [21:0]      exp_last;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [21:0] addr, input logic [15:0] len,
                               input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                               input int glitch_at, input logic [21:0] exp_last);
      vec_t v;
      v.we        = we;
      v.addr      = addr;
      v.len       = len;
      v.wd        = {16'h0000, w2, w1, w0};
      v.glitch_at = glitch_at;
      v.exp_last  = exp_last;
      return v;
   endfunction

   task automatic start_cmd(input vec_t v, input logic rdy);
      @(negedge clk);
      acc_base  = acc_n;
      rd_base   = rd_n;
      wr_base   = wr_n;
      done_base = done_n;
      ack_base  = ack_n;
      rd_ready  = rdy;
      cmd_start = 1'b1;
      cmd_we    = v.we;
      cmd_addr  = v.addr;
      cmd_len   = v.len;
      wr_valid  = v.we && (v.len != 16'd0);
      wr_data   = v.wd[0];
   endtask

   task automatic drive_until_done(input vec_t v, input string nm);
      bit seen;
      int idx;
      seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         cmd_start = 1'b0;
         if (k == v.glitch_at) begin
            cmd_start = 1'b1;
            cmd_we    = ~v.we;
            cmd_addr  = 22'h2AAAAA;
            cmd_len   = 16'd9;
         end
         idx      = wr_n - wr_base;
         wr_valid = v.we && (idx < int'(v.len));
         wr_data  = v.wd[idx[1:0]];
         seen     = (done_n != done_base);
      end
      chk($sformatf("%s done_seen", nm), {31'd0, seen}, 32'd1);
      cmd_start = 1'b0;
      wr_valid  = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_vec(input vec_t v, input string nm);
      int n;
      logic [21:0] ea;
      n = acc_n - acc_base;
      chk($sformatf("%s acc_cnt", nm), n, {16'd0, v.len});
      for (int i = 0; i < int'(v.len) && i < n; i++) begin
         ea = v.addr + 22'(i);
         chk($sformatf("%s addr[%0d]", nm, i), {10'd0, acc_addr[acc_base+i]}, {10'd0, ea});
         chk($sformatf("%s we[%0d]", nm, i), {31'd0, acc_we[acc_base+i]}, {31'd0, v.we});
         chk($sformatf("%s ds[%0d]", nm, i), {30'd0, acc_ds[acc_base+i]}, 32'd0);
         if (v.we) chk($sformatf("%s din[%0d]", nm, i), {16'd0, acc_din[acc_base+i]}, {16'd0, v.wd[i[1:0]]});
      end
      if (v.len != 16'd0 && n >= int'(v.len))
         chk($sformatf("%s last_addr", nm), {10'd0, acc_addr[acc_base+int'(v.len)-1]}, {10'd0, v.exp_last});
      if (!v.we) begin
         chk($sformatf("%s rd_cnt", nm), rd_n - rd_base, {16'd0, v.len});
         for (int i = 0; i < int'(v.len) && i < (rd_n - rd_base); i++)
            chk($sformatf("%s rd_data[%0d]", nm, i), {16'd0, rd_got[rd_base+i]},
                {16'd0, rd_pat(v.addr + 22'(i))});
      end
      chk($sformatf("%s wr_cnt", nm), wr_n - wr_base, v.we ? {16'd0, v.len} : 32'd0);
      chk($sformatf("%s done_cnt", nm), done_n - done_base, 32'd1);
      chk($sformatf("%s busy_after", nm), {31'd0, busy}, 32'd0);
   endtask

   vec_t vecs[6];

   initial begin
      vec_t v;
      bit   found;
      vecs[0] = mk(1'b0, 22'h000100, 16'd3, 16'h0, 16'h0, 16'h0, -1, 22'h000102);
      vecs[1] = mk(1'b1, 22'h000100, 16'd2, 16'hA55A, 16'h1234, 16'h0, -1, 22'h000101);
      vecs[2] = mk(1'b0, 22'h3FFFFF, 16'd2, 16'h0, 16'h0, 16'h0, -1, 22'h000000);
      vecs[3] = mk(1'b0, 22'h000200, 16'd0, 16'h0, 16'h0, 16'h0, -1, 22'h000000);
      vecs[4] = mk(1'b1, 22'h3FFFFE, 16'd3, 16'h0F0F, 16'hFFFF, 16'h0001, -1, 22'h000000);
      vecs[5] = mk(1'b0, 22'h000600, 16'd3, 16'h0, 16'h0, 16'h0, 4, 22'h000602);

      // Reset values, then a start strobe during SETTLE that must be ignored
      repeat (3) @(negedge clk);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst wr_ready", {31'd0, wr_ready}, 32'd0);
      chk("rst rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst p2_cs", {31'd0, p2_cs}, 32'd0);
      chk("rst p2_we", {31'd0, p2_we}, 32'd0);
      chk("rst p2_addr", {10'd0, p2_addr}, 32'd0);
      chk("rst p2_din", {16'd0, p2_din}, 32'd0);
      chk("rst p2_ds", {30'd0, p2_ds}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      cmd_start = 1'b1; cmd_we = 1'b0; cmd_addr = 22'h000123; cmd_len = 16'd1;
      @(negedge clk);
      cmd_start = 1'b0;
      chk("settle start busy", {31'd0, busy}, 32'd0);
      repeat (SETTLE + 4) @(negedge clk);
      chk("settle start acc", acc_n, 32'd0);
      chk("settle start done", done_n, 32'd0);

      for (int t = 0; t < 6; t++) begin
         start_cmd(vecs[t], 1'b1);
         drive_until_done(vecs[t], $sformatf("v%0d", t));
         check_vec(vecs[t], $sformatf("v%0d", t));
      end

      // Single read with rd_ready low: start->cs, ack->rd_valid, ack->done latencies
      v = mk(1'b0, 22'h000055, 16'd1, 16'h0, 16'h0, 16'h0, -1, 22'h000055);
      start_cmd(v, 1'b0);
      @(negedge clk);
      cmd_start = 1'b0;
      chk("lat cs_c1", {31'd0, p2_cs}, 32'd0);
      chk("lat busy_c1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("lat cs_c2", {31'd0, p2_cs}, 32'd1);
      chk("lat addr_c2", {10'd0, p2_addr}, 32'h55);
      chk("lat we_c2", {31'd0, p2_we}, 32'd0);
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         found = (ack_n != ack_base);
      end
      chk("lat ack_seen", {31'd0, found}, 32'd1);
      chk("lat cs_detect", {31'd0, p2_cs}, 32'd1);
      chk("lat rdv_detect", {31'd0, rd_valid}, 32'd0);
      @(negedge clk);
      chk("lat rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("lat rd_data", {16'd0, rd_data}, {16'd0, rd_pat(22'h000055)});
      chk("lat cs_low", {31'd0, p2_cs}, 32'd0);
      chk("lat done_early", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("lat done", {31'd0, done}, 32'd1);
      chk("lat busy_low", {31'd0, busy}, 32'd0);
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      chk("lat popped", {31'd0, rd_valid}, 32'd0);
      chk("lat ack_to_done", done_cyc - last_ack_cyc, 32'd2);
      chk("lat done_cnt", done_n - done_base, 32'd1);

      // Zero length: done two cycles after cmd_start, no access
      v = mk(1'b0, 22'h000200, 16'd0, 16'h0, 16'h0, 16'h0, -1, 22'h0);
      start_cmd(v, 1'b1);
      @(negedge clk);
      cmd_start = 1'b0;
      chk("zl done_c1", {31'd0, done}, 32'd0);
      chk("zl busy_c1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("zl done_c2", {31'd0, done}, 32'd1);
      chk("zl busy_c2", {31'd0, busy}, 32'd0);
      chk("zl cs", {31'd0, p2_cs}, 32'd0);
      @(negedge clk);
      chk("zl done_c3", {31'd0, done}, 32'd0);
      chk("zl acc", acc_n - acc_base, 32'd0);

      // Backpressure: six reads into a four-word FIFO with rd_ready low
      v = mk(1'b0, 22'h000300, 16'd6, 16'h0, 16'h0, 16'h0, -1, 22'h000305);
      start_cmd(v, 1'b0);
      @(negedge clk);
      cmd_start = 1'b0;
      repeat (80) @(negedge clk);
      chk("bp acc_stall", acc_n - acc_base, 32'd4);
      chk("bp cs_low", {31'd0, p2_cs}, 32'd0);
      chk("bp rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("bp busy", {31'd0, busy}, 32'd1);
      rd_ready = 1'b1;
      drive_until_done(v, "bp");
      check_vec(v, "bp");

      // Reset while REQ waits; the model's ack lands after reset release
      v = mk(1'b0, 22'h000400, 16'd2, 16'h0, 16'h0, 16'h0, -1, 22'h000401);
      start_cmd(v, 1'b1);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         cmd_start = 1'b0;
         found = m_pend;
      end
      chk("rm pending", {31'd0, found}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rm p2_cs", {31'd0, p2_cs}, 32'd0);
      chk("rm busy", {31'd0, busy}, 32'd0);
      chk("rm done", {31'd0, done}, 32'd0);
      chk("rm p2_addr", {10'd0, p2_addr}, 32'd0);
      chk("rm p2_din", {16'd0, p2_din}, 32'd0);
      chk("rm p2_we", {31'd0, p2_we}, 32'd0);
      repeat (SETTLE + 10) @(negedge clk);
      chk("rm stale_ack", ack_n - ack_base, 32'd1);
      chk("rm no_done", done_n - done_base, 32'd0);
      chk("rm no_push", {31'd0, rd_valid}, 32'd0);
      chk("rm no_pop", rd_n - rd_base, 32'd0);
      v = mk(1'b0, 22'h000500, 16'd1, 16'h0, 16'h0, 16'h0, -1, 22'h000500);
      start_cmd(v, 1'b1);
      drive_until_done(v, "rm_new");
      check_vec(v, "rm_new");

      chk("fifo_overflow", ovf_n, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
